// File: rtl/car_odometer.sv
// Car odometer: counts distance in mileage units while the car is driving.
// A 32-bit prescaler divides clk by DIV; each wrap advances a 4-digit
// packed-BCD mileage register and emits a one-cycle unit_tick.
// Optional feature macro: ODO_SATURATE_EN
//   defined   -> mileage sticks at 9999 and ovf is sticky until clear/OFF/reset
//   undefined -> mileage wraps 9999 -> 0000 and ovf pulses with that tick
module car_odometer #(
    parameter logic [31:0] DIV = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        moving,
    input  logic        clear,
    output logic [15:0] mile,
    output logic        unit_tick,
    output logic        ovf
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_STOP  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [31:0] DIV_M1 = DIV - 32'd1;

    state_t      state_q;
    logic [31:0] presc_q;
    logic [15:0] mile_q;
    logic        tick_q;
    logic        ovf_q;

    logic [16:0] mile_inc;
    logic        presc_hit;

    // Ripple-carry BCD increment; bit 16 is the carry out of digit 3.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [16:0] r;
        logic        c;
        r = '0;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c && (v[i*4 +: 4] == 4'd9)) begin
                r[i*4 +: 4] = 4'd0;
                c = 1'b1;
            end else if (c) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                c = 1'b0;
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        r[16] = c;
        return r;
    endfunction

    // Next mileage value and prescaler terminal-count detection.
    always_comb begin
        mile_inc  = bcd_inc(mile_q);
        presc_hit = (presc_q == DIV_M1);
    end

    // Power/drive state machine together with prescaler, mileage and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_OFF;
            presc_q <= 32'd0;
            mile_q  <= 16'h0000;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
`ifdef ODO_SATURATE_EN
            ovf_q  <= ovf_q;
`else
            ovf_q  <= 1'b0;
`endif
            if (mode == 2'b00) begin
                // Power off dominates everything, including a due increment.
                state_q <= ST_OFF;
                presc_q <= 32'd0;
                mile_q  <= 16'h0000;
                ovf_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_OFF:   state_q <= ST_STOP;
                    ST_STOP:  if (moving)  state_q <= ST_DRIVE;
                    ST_DRIVE: if (!moving) state_q <= ST_STOP;
                    default:  state_q <= ST_OFF;
                endcase

                if (state_q != ST_OFF) begin
                    if (clear) begin
                        presc_q <= 32'd0;
                        mile_q  <= 16'h0000;
                        ovf_q   <= 1'b0;
                    end else if (state_q == ST_DRIVE) begin
                        if (presc_hit) begin
                            presc_q <= 32'd0;
                            tick_q  <= 1'b1;
                            if (mile_inc[16]) begin
`ifdef ODO_SATURATE_EN
                                ovf_q  <= 1'b1;
`else
                                mile_q <= mile_inc[15:0];
                                ovf_q  <= 1'b1;
`endif
                            end else begin
                                mile_q <= mile_inc[15:0];
                            end
                        end else begin
                            presc_q <= presc_q + 32'd1;
                        end
                    end
                end
            end
        end
    end

    assign mile      = mile_q;
    assign unit_tick = tick_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_car_odometer.sv
// Self-checking bench for car_odometer with DIV=4 against a decimal-integer
// reference model of the odometer's behaviour.
module tb_car_odometer;

    localparam int DIV = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic        moving;
    logic        clear;
    logic [15:0] mile;
    logic        unit_tick;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    // reference model: state 0=OFF 1=STOP 2=DRIVE, mileage as decimal integer
    int m_st;
    int m_mile;
    int m_presc;
    bit m_tick;
    bit m_ovf;

    car_odometer #(.DIV(32'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .moving    (moving),
        .clear     (clear),
        .mile      (mile),
        .unit_tick (unit_tick),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic bit has_bad_digit(input logic [15:0] v);
        bit bad;
        bad = 1'b0;
        for (int k = 0; k < 4; k++)
            if (v[k*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    task automatic model_reset();
        m_st = 0; m_mile = 0; m_presc = 0; m_tick = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] md, input logic mv, input logic cl);
        int old;
        m_tick = 1'b0;
`ifndef ODO_SATURATE_EN
        m_ovf = 1'b0;
`endif
        if (md == 2'b00) begin
            m_st = 0; m_mile = 0; m_presc = 0; m_ovf = 1'b0;
        end else begin
            old = m_st;
            if (old == 0) m_st = 1;
            else if (old == 1 && mv) m_st = 2;
            else if (old == 2 && !mv) m_st = 1;
            if (old != 0) begin
                if (cl) begin
                    m_mile = 0; m_presc = 0; m_ovf = 1'b0;
                end else if (old == 2) begin
                    if (m_presc == DIV - 1) begin
                        m_presc = 0;
                        m_tick = 1'b1;
                        if (m_mile == 9999) begin
                            m_ovf = 1'b1;
`ifndef ODO_SATURATE_EN
                            m_mile = 0;
`endif
                        end else begin
                            m_mile = m_mile + 1;
                        end
                    end else begin
                        m_presc = m_presc + 1;
                    end
                end
            end
        end
    endtask

    // apply inputs, take one rising edge, advance model, sample 1 time unit later
    task automatic step(input logic [1:0] md, input logic mv, input logic cl);
        mode = md; moving = mv; clear = cl;
        @(posedge clk);
        model_edge(md, mv, cl);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mode = 2'b00; moving = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mode = 2'b01; moving = 1'b1; clear = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: mile=%h tick=%b ovf=%b expected 0000 0 0", mile, unit_tick, ovf);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_held: mile=%h tick=%b ovf=%b expected 0000 0 0", mile, unit_tick, ovf);
        end
        #3;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_basic_drive();
        int drive_edges;
        do_reset();
        step(2'b01, 1'b1, 1'b0);   // OFF -> STOP
        step(2'b01, 1'b1, 1'b0);   // STOP -> DRIVE
        for (drive_edges = 1; drive_edges <= 40; drive_edges++) begin
            step(2'b01, 1'b1, 1'b0);
            checks++;
            if ({mile, unit_tick, ovf} !== {to_bcd(m_mile), m_tick, m_ovf}
                || unit_tick !== ((drive_edges % 4) == 0)) begin
                errors++;
                $display("FAIL basic_drive edge %0d: mile=%h tick=%b ovf=%b expected mile=%h tick=%b ovf=%b",
                         drive_edges, mile, unit_tick, ovf, to_bcd(m_mile), m_tick, m_ovf);
            end
        end
        checks++;
        if (mile !== 16'h0010) begin
            errors++;
            $display("FAIL basic_drive_40: mile=%h expected 0010", mile);
        end
    endtask

    task automatic test_prescaler_retain();
        do_reset();
        step(2'b01, 1'b1, 1'b0);   // OFF -> STOP
        step(2'b01, 1'b1, 1'b0);   // STOP -> DRIVE (prescaler 0)
        step(2'b01, 1'b1, 1'b0);   // prescaler 1
        step(2'b01, 1'b0, 1'b0);   // prescaler 2, DRIVE -> STOP
        for (int i = 0; i < 10; i++) step(2'b10, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(2'b11, 1'b1, 1'b0);
            checks++;
            if (unit_tick !== (i == 3) || unit_tick !== m_tick
                || mile !== ((i == 3) ? 16'h0001 : 16'h0000)) begin
                errors++;
                $display("FAIL prescaler_retain edge %0d: tick=%b mile=%h expected tick=%b mile=%h",
                         i, unit_tick, mile, (i == 3), (i == 3) ? 16'h0001 : 16'h0000);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] md;
        logic mv, cl;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            md = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            mv = ($urandom_range(0, 9) < 7);
            cl = ($urandom_range(0, 63) == 0);
            step(md, mv, cl);
            checks++;
            if ({mile, unit_tick, ovf} !== {to_bcd(m_mile), m_tick, m_ovf}) begin
                errors++;
                $display("FAIL random edge %0d: mile=%h tick=%b ovf=%b expected mile=%h tick=%b ovf=%b",
                         i, mile, unit_tick, ovf, to_bcd(m_mile), m_tick, m_ovf);
            end
        end
    endtask

    task automatic test_clear_priority();
        int n;
        do_reset();
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        n = 0;
        while (!(m_mile >= 2 && m_presc == DIV - 1) && n < 100) begin
            step(2'b01, 1'b1, 1'b0);
            n++;
        end
        step(2'b01, 1'b1, 1'b1);
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear_priority: mile=%h tick=%b ovf=%b expected 0000 0 0", mile, unit_tick, ovf);
        end
        // after clear the prescaler restarts from 0: next tick DIV edges later
        for (int i = 1; i <= DIV; i++) begin
            step(2'b01, 1'b1, 1'b0);
            checks++;
            if (unit_tick !== (i == DIV) || mile !== ((i == DIV) ? 16'h0001 : 16'h0000)) begin
                errors++;
                $display("FAIL clear_restart edge %0d: tick=%b mile=%h", i, unit_tick, mile);
            end
        end
    endtask

    task automatic test_off_midrive();
        int n;
        do_reset();
        step(2'b10, 1'b1, 1'b0);
        step(2'b10, 1'b1, 1'b0);
        n = 0;
        while (!(m_mile >= 1 && m_presc == DIV - 1) && n < 100) begin
            step(2'b10, 1'b1, 1'b0);
            n++;
        end
        step(2'b00, 1'b1, 1'b0);
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL off_midrive: mile=%h tick=%b ovf=%b expected 0000 0 0", mile, unit_tick, ovf);
        end
        // clear while OFF has no effect; OFF->STOP->DRIVE then DIV edges to a tick
        step(2'b00, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        for (int i = 1; i <= DIV; i++) step(2'b01, 1'b1, 1'b0);
        checks++;
        if (unit_tick !== 1'b1 || mile !== 16'h0001) begin
            errors++;
            $display("FAIL off_restart: tick=%b mile=%h expected 1 0001", unit_tick, mile);
        end
    endtask

    task automatic test_bcd_ripple();
        bit seen100, seen1000;
        int n;
        do_reset();
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        seen100 = 0; seen1000 = 0; n = 0;
        while (!seen1000 && n < 5000) begin
            step(2'b01, 1'b1, 1'b0);
            n++;
            checks++;
            if ({mile, unit_tick, ovf} !== {to_bcd(m_mile), m_tick, m_ovf} || has_bad_digit(mile)) begin
                errors++;
                $display("FAIL bcd_run edge %0d: mile=%h tick=%b ovf=%b expected mile=%h tick=%b ovf=%b",
                         n, mile, unit_tick, ovf, to_bcd(m_mile), m_tick, m_ovf);
            end
            if (m_tick && m_mile == 100) begin
                seen100 = 1;
                checks++;
                if (mile !== 16'h0100) begin
                    errors++;
                    $display("FAIL bcd_0099_to_0100: mile=%h expected 0100", mile);
                end
            end
            if (m_tick && m_mile == 1000) begin
                seen1000 = 1;
                checks++;
                if (mile !== 16'h1000) begin
                    errors++;
                    $display("FAIL bcd_0999_to_1000: mile=%h expected 1000", mile);
                end
            end
        end
        if (!seen100 || !seen1000) begin
            checks++;
            errors++;
            $display("FAIL bcd_timeout: seen100=%0d seen1000=%0d after %0d edges expected both 1", seen100, seen1000, n);
        end
    endtask

    // continues driving from the state left by test_bcd_ripple
    task automatic test_overflow();
        int n;
        n = 0;
        while (!(m_mile == 9999 && m_presc == DIV - 1) && n < 40000) begin
            step(2'b01, 1'b1, 1'b0);
            n++;
            if (m_tick) begin
                checks++;
                if ({mile, unit_tick, ovf} !== {to_bcd(m_mile), m_tick, m_ovf} || has_bad_digit(mile)) begin
                    errors++;
                    $display("FAIL ovf_run edge %0d: mile=%h tick=%b ovf=%b expected mile=%h", n, mile, unit_tick, ovf, to_bcd(m_mile));
                end
            end
        end
        if (n >= 40000) begin
            checks++;
            errors++;
            $display("FAIL ovf_timeout: model mile=%0d after %0d edges, expected to reach 9999", m_mile, n);
        end
        checks++;
        if (mile !== 16'h9999 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre: mile=%h ovf=%b expected 9999 0", mile, ovf);
        end
        step(2'b01, 1'b1, 1'b0);
`ifdef ODO_SATURATE_EN
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h9999, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_saturate: mile=%h tick=%b ovf=%b expected 9999 1 1", mile, unit_tick, ovf);
        end
        for (int i = 0; i < DIV; i++) step(2'b01, 1'b1, 1'b0);
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h9999, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_sticky: mile=%h tick=%b ovf=%b expected 9999 1 1", mile, unit_tick, ovf);
        end
        step(2'b01, 1'b1, 1'b1);
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovf_clear: mile=%h tick=%b ovf=%b expected 0000 0 0", mile, unit_tick, ovf);
        end
`else
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_wrap: mile=%h tick=%b ovf=%b expected 0000 1 1", mile, unit_tick, ovf);
        end
        step(2'b01, 1'b1, 1'b0);
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovf_pulse_end: mile=%h tick=%b ovf=%b expected 0000 0 0", mile, unit_tick, ovf);
        end
`endif
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        n = 0;
        while (!(m_tick && m_mile >= 3) && n < 100) begin
            step(2'b01, 1'b1, 1'b0);
            n++;
        end
        checks++;
        if (unit_tick !== 1'b1 || mile !== 16'h0003) begin
            errors++;
            $display("FAIL async_pre: tick=%b mile=%h expected 1 0003", unit_tick, mile);
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({mile, unit_tick, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: mile=%h tick=%b ovf=%b expected 0000 0 0", mile, unit_tick, ovf);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        // OFF -> STOP -> DRIVE then DIV edges to the first tick
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        for (int i = 1; i <= DIV; i++) begin
            step(2'b01, 1'b1, 1'b0);
            checks++;
            if ({mile, unit_tick} !== {((i == DIV) ? 16'h0001 : 16'h0000), (i == DIV)}) begin
                errors++;
                $display("FAIL async_recover edge %0d: mile=%h tick=%b", i, mile, unit_tick);
            end
        end
    endtask

    initial begin
        reset = 1'b0; mode = 2'b00; moving = 1'b0; clear = 1'b0;
        model_reset();
        test_reset();
        test_basic_drive();
        test_prescaler_retain();
        test_clear_priority();
        test_off_midrive();
        test_random();
        test_async_reset();
        test_bcd_ripple();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_odometer.md
CAR_ODOMETER -- requirements
Module: car_odometer

Interface
REQ-001 SHALL have parameter DIV, default 50_000_000, clk cycles per mileage unit; legal range 2..2^32-1.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 SHALL have port mode  input  2  car power/drive mode: 00 off, 01 manual, 10 auto, 11 semi-auto.
REQ-005 SHALL have port moving  input  1  level; 1 while car is driving forward or turning.
REQ-006 SHALL have port clear  input  1  synchronous request to zero the mileage.
REQ-007 SHALL have port mile  output  16  4-digit packed BCD mileage, digit 3 at [15:12], registered.
REQ-008 SHALL have port unit_tick  output  1  one-cycle pulse on each mileage increment.
REQ-009 SHALL have port ovf  output  1  overflow indication (see REQ-025).

Function
REQ-010 SHALL implement states OFF, STOP, DRIVE in a registered state machine.
REQ-011 OFF -> STOP when mode != 00; any state -> OFF when mode == 00; STOP -> DRIVE when moving=1; DRIVE -> STOP when moving=0.
REQ-012 SHALL evaluate transitions every edge; state register change takes effect the edge after the input change.
REQ-013 In OFF, mile, prescaler and ovf SHALL be held at 0; unit_tick SHALL be 0.
REQ-014 SHALL keep a 32-bit prescaler that increments by 1 each edge only while state is DRIVE.
REQ-015 In STOP, prescaler SHALL hold its value (fractional distance retained across stops).
REQ-016 When state is DRIVE and prescaler == DIV-1, next edge: prescaler -> 0, mile -> mile+1 (BCD), unit_tick -> 1 for exactly that cycle.
REQ-017 First increment after entering DRIVE from prescaler 0 SHALL occur DIV edges after the edge that enters DRIVE.
REQ-018 BCD increment SHALL ripple: digit 9 -> 0 with carry into next digit; no digit SHALL ever hold A-F.
REQ-019 clear=1 in STOP or DRIVE SHALL, on next edge, set mile=0, prescaler=0, ovf=0, unit_tick=0; clear has priority over a coincident increment.
REQ-020 clear in OFF SHALL have no additional effect.
REQ-021 mode change between non-00 values SHALL NOT alter mile, prescaler or state.
REQ-022 mode -> 00 during DRIVE with prescaler == DIV-1 SHALL NOT increment; OFF behaviour wins.
REQ-023 mile SHALL change only on edges where unit_tick is asserted, or on clear/OFF zeroing.

Reset
REQ-024 While reset=0, state=OFF, mile=16'h0000, prescaler=0, unit_tick=0, ovf=0, immediately and independent of clk; normal operation from first rising edge after reset returns to 1.

Configuration
REQ-025 Macro ODO_SATURATE_EN: when defined, an increment at mile=16'h9999 SHALL leave mile at 9999, set ovf=1 sticky until clear/OFF/reset, and still pulse unit_tick; when undefined, mile SHALL wrap 9999 -> 0000, ovf SHALL be a one-cycle pulse coincident with that unit_tick.

Verification
REQ-026 DIV=4, reset, mode=01, moving=1 held -> unit_tick every 4 edges, mile 0000,0001,... after 40 edges in DRIVE mile=0010.
REQ-027 DIV=4, drive 2 edges, moving=0 for 10 edges, moving=1 -> first tick after 2 further DRIVE edges (prescaler retained).
REQ-028 DIV=4, mile at 0099 then one unit -> mile=0100; at 0999 -> 1000; no non-BCD digit ever observed.
REQ-029 mile=9999, one unit: with ODO_SATURATE_EN -> mile=9999, ovf=1 sticky; without -> mile=0000, ovf pulse 1 cycle.
REQ-030 clear=1 on same edge as due increment -> mile=0000, unit_tick=0; mode=00 mid-drive -> mile=0000 next edge; reset=0 asynchronously mid-cycle -> all outputs 0 before next edge.
